// File: rtl/tela_pkg.sv
// Shared types and constants for the tela_sprites overlay: slot attribute record,
// raster geometry defaults and the bitmap-coordinate scaling helper.
package tela_pkg;

    localparam int VIS_W     = 640;
    localparam int VIS_H     = 480;
    localparam int H_OFF_DEF = 144;
    localparam int V_OFF_DEF = 35;

    localparam logic [23:0] BG_RGB_DEF = 24'h003232;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [1:0]  scale;
        logic [23:0] rgb;
        logic        en;
    } slot_attr_t;

    // Map an offset inside a scaled sprite back to a bitmap coordinate (factor = s+1).
    function automatic logic [9:0] unscale(input logic [9:0] d, input logic [1:0] s);
        case (s)
            2'd0:    return d;
            2'd1:    return d >> 1;
            2'd2:    return d / 10'd3;
            default: return d >> 2;
        endcase
    endfunction

endpackage

// File: rtl/sprite_rom.sv
// Per-slot sprite masks: a solid block with a slot-dependent grid of transparent
// holes (every 4th row, at columns congruent to the slot number mod 4).
module sprite_rom
    import tela_pkg::*;
#(
    parameter int SPRITE_W = 15,
    parameter int SPRITE_H = 16
) (
    input  logic [2:0]                  slot,
    input  logic [$clog2(SPRITE_H)-1:0] row,
    input  logic [$clog2(SPRITE_W)-1:0] col,
    output logic                        mask
);

    always_comb begin
        mask = 1'b1;
        if ((int'(row) % 4 == 3) && (int'(col) % 4 == int'(slot) % 4))
            mask = 1'b0;
    end

endmodule

// File: rtl/tela_sprites.sv
// Sprite overlay for a VGA raster: double-buffered slot attributes, 2-stage pixel pipeline.
// Optional macro TELA_SPRITES_COLLISION_EN adds the sticky pairwise colisao output.
module tela_sprites
    import tela_pkg::*;
#(
    parameter int          N_SPRITES = 4,
    parameter int          SPRITE_W  = 15,
    parameter int          SPRITE_H  = 16,
    parameter int          H_OFF     = H_OFF_DEF,
    parameter int          V_OFF     = V_OFF_DEF,
    parameter logic [23:0] BG_RGB    = BG_RGB_DEF
) (
    input  logic        VGA_CLK,
    input  logic        reset,
    input  logic        ativo,
    input  logic        perdeu,
    input  logic [9:0]  VGA_X,
    input  logic [9:0]  VGA_Y,
    // wr_* is a valid/ready port: a write transfers on a VGA_CLK edge where
    // wr_valid and wr_ready are both high; wr_ready drops only in the commit cycle.
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [2:0]  wr_idx,
    input  logic [9:0]  wr_x,
    input  logic [9:0]  wr_y,
    input  logic [1:0]  wr_scale,
    input  logic [23:0] wr_rgb,
    input  logic        wr_en,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B
`ifdef TELA_SPRITES_COLLISION_EN
    ,
    output logic [N_SPRITES*N_SPRITES-1:0] colisao
`endif
);

    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);

    slot_attr_t shadow [N_SPRITES];
    slot_attr_t active [N_SPRITES];

    logic commit;
    assign commit   = (VGA_X == 10'd0) && (VGA_Y == 10'd0);
    assign wr_ready = reset | ~commit;

    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            // Indices with no matching slot fall through the loop and are dropped.
            for (int i = 0; i < N_SPRITES; i++) begin
                if (wr_valid && wr_ready && wr_idx == 3'(i))
                    shadow[i] <= '{x: wr_x, y: wr_y, scale: wr_scale, rgb: wr_rgb, en: wr_en};
                if (commit)
                    active[i] <= shadow[i];
            end
        end
    end

    // Stage 1: raster to visible coordinates, per-slot hit test and bitmap coordinates.
    logic [9:0]          px, py;
    logic                vis;
    logic [N_SPRITES-1:0] hit_n;
    logic [CW-1:0]       col_n [N_SPRITES];
    logic [RW-1:0]       row_n [N_SPRITES];

    assign px  = VGA_X - 10'(H_OFF);
    assign py  = VGA_Y - 10'(V_OFF);
    assign vis = (px < 10'(VIS_W)) && (py < 10'(VIS_H));

    always_comb begin
        logic [11:0] fac, x_lo, x_hi, y_lo, y_hi;
        for (int i = 0; i < N_SPRITES; i++) begin
            fac  = {10'd0, active[i].scale} + 12'd1;
            x_lo = {2'b00, active[i].x};
            y_lo = {2'b00, active[i].y};
            x_hi = x_lo + 12'(SPRITE_W) * fac;
            y_hi = y_lo + 12'(SPRITE_H) * fac;
            hit_n[i] = vis && active[i].en
                     && ({2'b00, px} >= x_lo) && ({2'b00, px} < x_hi)
                     && ({2'b00, py} >= y_lo) && ({2'b00, py} < y_hi);
            col_n[i] = CW'(unscale(px - active[i].x, active[i].scale));
            row_n[i] = RW'(unscale(py - active[i].y, active[i].scale));
        end
    end

    logic [N_SPRITES-1:0] hit_q;
    logic [CW-1:0]        col_q [N_SPRITES];
    logic [RW-1:0]        row_q [N_SPRITES];
    logic                 ativo_q, perdeu_q;

    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            hit_q    <= '0;
            ativo_q  <= 1'b0;
            perdeu_q <= 1'b0;
            for (int i = 0; i < N_SPRITES; i++) begin
                col_q[i] <= '0;
                row_q[i] <= '0;
            end
        end else begin
            hit_q    <= hit_n;
            ativo_q  <= ativo;
            perdeu_q <= perdeu;
            for (int i = 0; i < N_SPRITES; i++) begin
                col_q[i] <= col_n[i];
                row_q[i] <= row_n[i];
            end
        end
    end

    // Stage 2: mask lookup and priority select.
    logic [N_SPRITES-1:0] mask_b, draw;

    for (genvar g = 0; g < N_SPRITES; g++) begin : g_rom
        sprite_rom #(
            .SPRITE_W (SPRITE_W),
            .SPRITE_H (SPRITE_H)
        ) u_rom (
            .slot (3'(g)),
            .row  (row_q[g]),
            .col  (col_q[g]),
            .mask (mask_b[g])
        );
    end

    assign draw = hit_q & mask_b;

    // Reading rgb from the active set here is safe: the only pixel in stage 2 right
    // after a commit is the one presented at (0,0), which lies outside the visible area.
    logic [23:0] rgb_n, rgb_q;

    always_comb begin
        rgb_n = BG_RGB;
        for (int i = N_SPRITES - 1; i >= 0; i--)
            if (draw[i])
                rgb_n = active[i].rgb;
    end

    always_ff @(posedge VGA_CLK) begin
        if (reset)
            rgb_q <= '0;
        else if (!ativo_q || perdeu_q)
            rgb_q <= '0;
        else
            rgb_q <= rgb_n;
    end

    assign VGA_R = rgb_q[23:16];
    assign VGA_G = rgb_q[15:8];
    assign VGA_B = rgb_q[7:0];

`ifdef TELA_SPRITES_COLLISION_EN
    logic [N_SPRITES*N_SPRITES-1:0] coll_n;

    always_comb begin
        coll_n = '0;
        for (int i = 0; i < N_SPRITES; i++)
            for (int j = 0; j < N_SPRITES; j++)
                if (j > i && draw[i] && draw[j])
                    coll_n[i*N_SPRITES+j] = 1'b1;
    end

    // Commit clears the flags, but a collision detected on the same edge survives.
    always_ff @(posedge VGA_CLK) begin
        if (reset)
            colisao <= '0;
        else
            colisao <= (commit ? '0 : colisao) | coll_n;
    end
`endif

endmodule

// File: doc/tela_sprites.md
TELA_SPRITES -- requirements
Module: tela_sprites

Interface
REQ-001 Parameter N_SPRITES, default 4, number of sprite slots (1..8); slot 0 has highest draw priority.
REQ-002 Parameter SPRITE_W, default 15, bitmap width in pixels; SPRITE_H, default 16, bitmap height in pixels.
REQ-003 Parameter H_OFF, default 144, and V_OFF, default 35: VGA_X/VGA_Y offsets of the first visible pixel.
REQ-004 Parameter BG_RGB, default 24'h003232, background colour used while ativo=1 and perdeu=0.
REQ-005 VGA_CLK  in  1  pixel clock; the only clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 ativo  in  1  game running; perdeu  in  1  game lost.
REQ-008 VGA_X  in  10  raster column; VGA_Y  in  10  raster row.
REQ-009 wr_valid  in  1  attribute write request; wr_ready  out  1  write accepted this cycle when high together with wr_valid.
REQ-010 wr_idx  in  3  slot index; wr_x  in  10  and wr_y  in  10  visible-area position; wr_scale  in  2  scale code (factor = wr_scale+1); wr_rgb  in  24  colour; wr_en  in  1  slot visible.
REQ-011 VGA_R, VGA_G, VGA_B  out  8 each  pixel colour, registered.

Function
REQ-012 Each slot SHALL have a shadow register set (written by the port) and an active set (used for drawing).
REQ-013 A write SHALL be accepted when wr_valid=1 and wr_ready=1; it updates the shadow set of slot wr_idx on that clock edge.
REQ-014 Writes with wr_idx >= N_SPRITES SHALL be accepted and discarded.
REQ-015 wr_ready SHALL be 1 except during the commit cycle.
REQ-016 The commit cycle SHALL be the cycle with VGA_X=0 and VGA_Y=0. In it, every shadow set is copied to its active set, and wr_ready is 0.
REQ-017 Mid-frame writes SHALL never change the current frame's image.
REQ-018 Pixel pipeline stage 1 SHALL:
- register px = VGA_X-H_OFF and py = VGA_Y-V_OFF (10-bit, wrapping);
- register per-slot hit flags, where a hit is x <= px < x+SPRITE_W*factor and y <= py < y+SPRITE_H*factor, evaluated in 12-bit unsigned arithmetic with no wrap;
- register per-slot bitmap coordinates (px-x)/factor and (py-y)/factor.
REQ-019 Pixel pipeline stage 2 SHALL:
- read the bitmap bit for each hit slot;
- select the lowest-index slot with hit=1, en=1 and bitmap bit=1;
- register that slot's rgb onto VGA_R/G/B.
REQ-020 If no slot is selected in stage 2, the output SHALL be BG_RGB.
REQ-021 Latency SHALL be exactly 2 VGA_CLK cycles from VGA_X/VGA_Y to VGA_R/G/B.
REQ-022 ativo and perdeu SHALL be delayed through the same 2-stage pipeline.
REQ-023 When the delayed ativo=0 or the delayed perdeu=1, the output SHALL be 0/0/0.
REQ-024 Pixels outside the visible area (px >= 640 or py >= 480 after wrap) SHALL never hit any slot.

Reset
REQ-025 On reset, all shadow and active sets SHALL clear: x=0, y=0, scale=0, rgb=0, en=0.
REQ-026 On reset, pipeline registers SHALL clear, VGA_R/G/B SHALL be 0, and wr_ready SHALL be 1.
REQ-027 Reset asserted mid-frame SHALL take effect on the next edge and discard any write presented in that cycle.

Configuration
REQ-028 With macro TELA_SPRITES_COLLISION_EN defined, the block SHALL add:
- output colisao [N_SPRITES*N_SPRITES-1:0];
- bit i*N_SPRITES+j (i<j) set sticky when slots i and j both have en=1, hit=1 and bitmap bit=1 on the same visible pixel;
- colisao cleared at each commit cycle (a set on the same cycle wins) and on reset.
REQ-029 Without TELA_SPRITES_COLLISION_EN, the colisao port and its logic SHALL be absent.

Structure
REQ-030 Package tela_pkg SHALL hold the slot attribute record type, the default BG_RGB, H_OFF/V_OFF, and the 640x480 visible-size constants.
REQ-031 Sub-module sprite_rom SHALL hold one SPRITE_W x SPRITE_H mask per slot. Its inputs are slot, row and column; its output is the mask bit, read combinationally in stage 2.

Verification
REQ-032 Write slot 0 (x=100, y=50, scale=0, rgb=FF0000, en=1) mid-frame: that frame, pixel (244,85) shows 003232; after the next commit it shows FF0000 two cycles after the coordinate is presented.
REQ-033 Slot 0 and slot 1 both at x=10, y=10 with set mask bits: slot 0's colour is output; disable slot 0 and commit: slot 1's colour is output.
REQ-034 Slot 2 at x=630, y=0, scale=3: the pixel at px=639 is sprite-coloured; px=0 of the next line is not (no wrap).
REQ-035 wr_valid held high across VGA_X=0, VGA_Y=0: wr_ready=0 for exactly that cycle and the write completes on the following cycle.
REQ-036 Drop ativo for one pixel: black appears exactly 2 cycles later for one cycle; reset mid-frame gives all outputs 0 on the next cycle.
REQ-037 (TELA_SPRITES_COLLISION_EN) Overlap slots 0 and 3 with N_SPRITES=4: bit 3 sets and holds until the next commit, then clears.
